idelay_tap_calibrator: RTL and testbench

- Sequences the fixed-clock oversampling receiver front end by sweeping the IDELAYE2 tap of the secondary (delayed) sample path in VAR_LOAD mode.
- For each tap, measures the bitwise mismatch between the reference 4-bit ISERDES word and the delayed-path word, then loads the tap with the lowest mismatch count.
- Sits in the CLKDIV domain between the ISERDESE2 outputs and the IDELAYE2 LD/CNTVALUEIN pins. Gated by IDELAYCTRL RDY.

---
 rtl/rx_cal_pkg.sv | 23 ++
 rtl/idelay_tap_calibrator_if.sv | 11 +
 rtl/mismatch_accumulator.sv | 46 ++++
 rtl/idelay_tap_calibrator.sv | 187 ++++++++++++++++++
 tb/tb_idelay_tap_calibrator.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_cal_pkg.sv
// Shared types, defaults and helpers for the IDELAY tap calibrator.
package rx_cal_pkg;

  localparam int unsigned TAP_W_DEF = 5;
  localparam int unsigned CNT_W_DEF = 11;
  localparam int unsigned SAMPLE_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    MEASURE,
    EVAL,
    APPLY,
    DONE
  } cal_state_e;

  // Number of differing bits between the two 4-bit sample words.
  function automatic logic [2:0] popcount4(input logic [SAMPLE_W-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/idelay_tap_calibrator_if.sv
// ISERDES sample bus: reference word, delayed word and common valid.
interface idelay_tap_calibrator_if;
  import rx_cal_pkg::*;

  logic [SAMPLE_W-1:0] sample_ref;
  logic [SAMPLE_W-1:0] sample_dly;
  logic                sample_valid;

  modport master (output sample_ref, sample_dly, sample_valid);
  modport slave  (input  sample_ref, sample_dly, sample_valid);
endinterface

// File: rtl/mismatch_accumulator.sv
// Saturating bit-mismatch accumulator over a window of valid sample cycles.
module mismatch_accumulator
  import rx_cal_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned WINDOW_CYCLES = 256
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] sample_ref,
  input  logic [SAMPLE_W-1:0] sample_dly,
  input  logic                sample_valid,
  output logic [CNT_W-1:0]    acc,
  output logic                window_done_c
);

  localparam int unsigned VCNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0]  ACC_MAX  = '1;
  localparam logic [VCNT_W-1:0] VCNT_END = VCNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0]  r_acc;
  logic [VCNT_W-1:0] r_vcnt;
  logic [SUM_W-1:0]  w_sum;

  assign w_sum = {1'b0, r_acc} + SUM_W'(popcount4(sample_ref ^ sample_dly));

  // Window closes on the cycle that accepts the last valid sample.
  assign window_done_c = !clear && sample_valid && (r_vcnt == VCNT_END);
  assign acc           = r_acc;

  always_ff @(posedge clk or negedge aresetn) begin : acc_reg
    if (!aresetn) begin
      r_acc  <= '0;
      r_vcnt <= '0;
    end else if (clear) begin
      r_acc  <= '0;
      r_vcnt <= '0;
    end else if (sample_valid) begin
      r_acc  <= w_sum[CNT_W] ? ACC_MAX : w_sum[CNT_W-1:0];
      r_vcnt <= r_vcnt + VCNT_W'(1);
    end
  end

endmodule

// File: rtl/idelay_tap_calibrator.sv
// Sweeps the IDELAYE2 tap, scores each tap by sample mismatch and loads the best.
// Optional per-tap mismatch history readback when CAL_HIST_EN is defined.
module idelay_tap_calibrator
  import rx_cal_pkg::*;
#(
  parameter int unsigned TAP_W         = TAP_W_DEF,
  parameter int unsigned NUM_TAPS      = 32,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   idelayctrl_ready,
  input  logic                   start,
  idelay_tap_calibrator_if.slave rx,
  output logic                   idelay_ld,
  output logic [TAP_W-1:0]       idelay_cntvalue,
  output logic                   busy,
  output logic                   done,
  output logic [TAP_W-1:0]       best_tap,
  output logic [CNT_W-1:0]       best_count
`ifdef CAL_HIST_EN
  ,
  input  logic [TAP_W-1:0]       hist_addr,
  output logic [CNT_W-1:0]       hist_data
`endif
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  cal_state_e       r_state, w_state_nxt;
  logic [TAP_W-1:0] r_tap, w_tap_nxt;
  logic [SET_W-1:0] r_settle, w_settle_nxt;
  logic             r_ld, w_ld_nxt;
  logic [TAP_W-1:0] r_cntvalue, w_cntvalue_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [TAP_W-1:0] r_best_tap, w_best_tap_nxt;
  logic [CNT_W-1:0] r_best_count, w_best_count_nxt;
  logic             w_clear;
  logic             w_window_done;
  logic             w_in_run;
  logic [CNT_W-1:0] w_acc;

  mismatch_accumulator #(
    .CNT_W         (CNT_W),
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_acc (
    .clk           (clk),
    .aresetn       (aresetn),
    .clear         (w_clear),
    .sample_ref    (rx.sample_ref),
    .sample_dly    (rx.sample_dly),
    .sample_valid  (rx.sample_valid),
    .acc           (w_acc),
    .window_done_c (w_window_done)
  );

  assign w_in_run = r_state inside {LOAD, SETTLE, MEASURE, EVAL, APPLY};

  always_ff @(posedge clk or negedge aresetn) begin : state_reg
    if (!aresetn) begin
      r_state      <= IDLE;
      r_tap        <= '0;
      r_settle     <= '0;
      r_ld         <= 1'b0;
      r_cntvalue   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_best_tap   <= '0;
      r_best_count <= '1;
    end else begin
      r_state      <= w_state_nxt;
      r_tap        <= w_tap_nxt;
      r_settle     <= w_settle_nxt;
      r_ld         <= w_ld_nxt;
      r_cntvalue   <= w_cntvalue_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_best_tap   <= w_best_tap_nxt;
      r_best_count <= w_best_count_nxt;
    end
  end

  // Outputs are computed for the next state so they line up with it once registered.
  always_comb begin : next_state
    w_state_nxt      = r_state;
    w_tap_nxt        = r_tap;
    w_settle_nxt     = r_settle;
    w_ld_nxt         = 1'b0;
    w_cntvalue_nxt   = r_cntvalue;
    w_best_tap_nxt   = r_best_tap;
    w_best_count_nxt = r_best_count;
    w_clear          = 1'b1;

    if (w_in_run && !idelayctrl_ready) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start && idelayctrl_ready) begin
            w_state_nxt      = LOAD;
            w_tap_nxt        = '0;
            w_best_count_nxt = '1;
            w_ld_nxt         = 1'b1;
            w_cntvalue_nxt   = '0;
          end
        end
        LOAD: begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = '0;
        end
        SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            w_state_nxt = MEASURE;
          end else begin
            w_settle_nxt = r_settle + SET_W'(1);
          end
        end
        MEASURE: begin
          w_clear = 1'b0;
          if (w_window_done) begin
            w_state_nxt = EVAL;
          end
        end
        EVAL: begin
          // Strict compare: on a tie the earlier (lower) tap stays selected.
          if (w_acc < r_best_count) begin
            w_best_count_nxt = w_acc;
            w_best_tap_nxt   = r_tap;
          end
          w_ld_nxt = 1'b1;
          if (r_tap == LAST_TAP) begin
            w_state_nxt    = APPLY;
            w_cntvalue_nxt = w_best_tap_nxt;
          end else begin
            w_tap_nxt      = r_tap + TAP_W'(1);
            w_state_nxt    = LOAD;
            w_cntvalue_nxt = w_tap_nxt;
          end
        end
        APPLY: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    w_busy_nxt = w_state_nxt inside {LOAD, SETTLE, MEASURE, EVAL, APPLY};
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign idelay_ld       = r_ld;
  assign idelay_cntvalue = r_cntvalue;
  assign busy            = r_busy;
  assign done            = r_done;
  assign best_tap        = r_best_tap;
  assign best_count      = r_best_count;

`ifdef CAL_HIST_EN
  logic [CNT_W-1:0] r_hist [NUM_TAPS];
  logic [CNT_W-1:0] r_hist_data;

  // Final mismatch of each tap, captured in EVAL; read port has one cycle latency.
  always_ff @(posedge clk or negedge aresetn) begin : hist_reg
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        r_hist[i] <= '0;
      end
      r_hist_data <= '0;
    end else begin
      if (r_state == EVAL) begin
        r_hist[r_tap] <= w_acc;
      end
      r_hist_data <= (32'(hist_addr) < NUM_TAPS) ? r_hist[hist_addr] : '0;
    end
  end

  assign hist_data = r_hist_data;
`endif

endmodule

// File: tb/tb_idelay_tap_calibrator.sv
// Directed bench for idelay_tap_calibrator; a second instance uses CNT_W=10 for saturation.
module tb_idelay_tap_calibrator;
  import rx_cal_pkg::*;

  localparam int MAX_CYC = 20000;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        ready;
  logic        start;

  logic        ld, ld_s;
  logic [4:0]  cnt, cnt_s;
  logic        busy, busy_s, done, done_s;
  logic [4:0]  best_tap, best_tap_s;
  logic [10:0] best_count;
  logic [9:0]  best_count_s;
`ifdef CAL_HIST_EN
  logic [4:0]  hist_addr;
  logic [10:0] hist_data;
  logic [9:0]  hist_data_s;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [4:0]  ld_log [0:39];
  int          n_ld;
  int          cyc;
  logic        first_busy, first_done;

  idelay_tap_calibrator_if rx();

  idelay_tap_calibrator u_dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .idelayctrl_ready (ready),
    .start            (start),
    .rx               (rx.slave),
    .idelay_ld        (ld),
    .idelay_cntvalue  (cnt),
    .busy             (busy),
    .done             (done),
    .best_tap         (best_tap),
    .best_count       (best_count)
`ifdef CAL_HIST_EN
    ,
    .hist_addr        (hist_addr),
    .hist_data        (hist_data)
`endif
  );

  idelay_tap_calibrator #(.CNT_W(10)) u_dut_sat (
    .clk              (clk),
    .aresetn          (aresetn),
    .idelayctrl_ready (ready),
    .start            (start),
    .rx               (rx.slave),
    .idelay_ld        (ld_s),
    .idelay_cntvalue  (cnt_s),
    .busy             (busy_s),
    .done             (done_s),
    .best_tap         (best_tap_s),
    .best_count       (best_count_s)
`ifdef CAL_HIST_EN
    ,
    .hist_addr        (hist_addr),
    .hist_data        (hist_data_s)
`endif
  );

  always #5 clk = ~clk;

  // Mismatch mask per tap: 0 equal, 1 only taps 10..14 equal, 2 tap 20 one bit else two, 3 all four.
  task automatic drive_samples(input int mode, input logic vld, input logic [4:0] tap);
    logic [3:0] r;
    logic [3:0] m;
    r = 4'($urandom_range(0, 15));
    case (mode)
      0:       m = 4'h0;
      1:       m = (tap >= 5'd10 && tap <= 5'd14) ? 4'h0 : 4'hF;
      2:       m = (tap == 5'd20) ? 4'b0100 : 4'b0011;
      default: m = 4'hF;
    endcase
    rx.sample_ref   = r;
    rx.sample_dly   = r ^ m;
    rx.sample_valid = vld;
  endtask

  // Pulse start, then follow the sweep until done, max_ld LD pulses, or the cycle budget.
  task automatic run_cal(input int mode, input logic toggle, input int max_ld);
    logic v;
    v    = 1'b1;
    n_ld = 0;
    @(negedge clk);
    start = 1'b1;
    drive_samples(mode, v, cnt);
    @(negedge clk);
    start      = 1'b0;
    cyc        = 1;
    first_busy = busy;
    first_done = done;
    while (cyc < MAX_CYC) begin
      if (ld) begin
        if (n_ld < 40) ld_log[n_ld] = cnt;
        n_ld++;
      end
      if (done || n_ld >= max_ld) break;
      if (toggle) v = ~v;
      drive_samples(mode, v, cnt);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    ready   = 1'b1;
    start   = 1'b0;
    rx.sample_ref   = '0;
    rx.sample_dly   = '0;
    rx.sample_valid = 1'b0;
`ifdef CAL_HIST_EN
    hist_addr = '0;
`endif
    #1 aresetn = 1'b0;
    #3;
    checks++; if (ld !== 1'b0) $display("FAIL reset_ld got=%b exp=0", ld); else passed++;
    checks++; if (cnt !== 5'd0) $display("FAIL reset_cntvalue got=%0d exp=0", cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (best_tap !== 5'd0) $display("FAIL reset_best_tap got=%0d exp=0", best_tap); else passed++;
    checks++; if (best_count !== 11'h7FF) $display("FAIL reset_best_count got=%0d exp=2047", best_count); else passed++;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_equal();
    run_cal(0, 1'b0, 99);
    checks++; if (first_busy !== 1'b1) $display("FAIL eq_busy_start got=%b exp=1", first_busy); else passed++;
    checks++; if (cyc !== 8514) $display("FAIL eq_latency got=%0d exp=8514", cyc); else passed++;
    checks++; if (n_ld !== 33) $display("FAIL eq_ld_count got=%0d exp=33", n_ld); else passed++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (ld_log[i] !== 5'(i)) $display("FAIL eq_ld_tap%0d got=%0d exp=%0d", i, ld_log[i], i);
      else passed++;
    end
    checks++; if (ld_log[32] !== 5'd0) $display("FAIL eq_apply_tap got=%0d exp=0", ld_log[32]); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL eq_done got=%b exp=1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL eq_busy_end got=%b exp=0", busy); else passed++;
    checks++; if (best_tap !== 5'd0) $display("FAIL eq_best_tap got=%0d exp=0", best_tap); else passed++;
    checks++; if (best_count !== 11'd0) $display("FAIL eq_best_count got=%0d exp=0", best_count); else passed++;
    checks++; if (cnt !== 5'd0) $display("FAIL eq_cntvalue got=%0d exp=0", cnt); else passed++;
  endtask

  task automatic test_saturation();
    run_cal(3, 1'b0, 99);
    checks++; if (done !== 1'b1) $display("FAIL sat_done got=%b exp=1", done); else passed++;
    checks++; if (best_tap !== 5'd0) $display("FAIL sat_best_tap got=%0d exp=0", best_tap); else passed++;
    checks++; if (best_count !== 11'd1024) $display("FAIL sat_best_count got=%0d exp=1024", best_count); else passed++;
    checks++; if (done_s !== 1'b1) $display("FAIL sat10_done got=%b exp=1", done_s); else passed++;
    checks++; if (best_tap_s !== 5'd0) $display("FAIL sat10_best_tap got=%0d exp=0", best_tap_s); else passed++;
    checks++; if (best_count_s !== 10'h3FF) $display("FAIL sat10_best_count got=%0d exp=1023", best_count_s); else passed++;
`ifdef CAL_HIST_EN
    for (int a = 0; a < 32; a += 15) begin
      hist_addr = 5'(a);
      @(negedge clk);
      checks++;
      if (hist_data !== 11'd1024) $display("FAIL hist_addr%0d got=%0d exp=1024", a, hist_data);
      else passed++;
      checks++;
      if (hist_data_s !== 10'd1023) $display("FAIL hist10_addr%0d got=%0d exp=1023", a, hist_data_s);
      else passed++;
    end
`endif
  endtask

  task automatic test_window_min();
    run_cal(1, 1'b0, 99);
    checks++; if (first_done !== 1'b0) $display("FAIL rerun_done_clear got=%b exp=0", first_done); else passed++;
    checks++; if (first_busy !== 1'b1) $display("FAIL rerun_busy got=%b exp=1", first_busy); else passed++;
    checks++; if (n_ld !== 33) $display("FAIL win_ld_count got=%0d exp=33", n_ld); else passed++;
    checks++; if (ld_log[32] !== 5'd10) $display("FAIL win_apply_tap got=%0d exp=10", ld_log[32]); else passed++;
    checks++; if (best_tap !== 5'd10) $display("FAIL win_best_tap got=%0d exp=10", best_tap); else passed++;
    checks++; if (best_count !== 11'd0) $display("FAIL win_best_count got=%0d exp=0", best_count); else passed++;
    checks++; if (cnt !== 5'd10) $display("FAIL win_cntvalue got=%0d exp=10", cnt); else passed++;
  endtask

  task automatic test_single_best();
    run_cal(2, 1'b0, 99);
    checks++; if (cyc !== 8514) $display("FAIL one_latency got=%0d exp=8514", cyc); else passed++;
    checks++; if (best_tap !== 5'd20) $display("FAIL one_best_tap got=%0d exp=20", best_tap); else passed++;
    checks++; if (best_count !== 11'd256) $display("FAIL one_best_count got=%0d exp=256", best_count); else passed++;
  endtask

  task automatic test_valid_toggle();
    run_cal(2, 1'b1, 99);
    checks++;
    if (cyc < 16674 || cyc > 16706) $display("FAIL tog_latency got=%0d exp=16674..16706", cyc);
    else passed++;
    checks++; if (done !== 1'b1) $display("FAIL tog_done got=%b exp=1", done); else passed++;
    checks++; if (best_tap !== 5'd20) $display("FAIL tog_best_tap got=%0d exp=20", best_tap); else passed++;
    checks++; if (best_count !== 11'd256) $display("FAIL tog_best_count got=%0d exp=256", best_count); else passed++;
  endtask

  task automatic test_abort();
    run_cal(2, 1'b0, 8);
    checks++; if (n_ld !== 8) $display("FAIL abort_ld_count got=%0d exp=8", n_ld); else passed++;
    checks++; if (ld_log[7] !== 5'd7) $display("FAIL abort_tap got=%0d exp=7", ld_log[7]); else passed++;
    for (int i = 0; i < 20; i++) begin
      drive_samples(2, 1'b1, cnt);
      @(negedge clk);
    end
    ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else passed++;
    checks++; if (ld !== 1'b0) $display("FAIL abort_ld got=%b exp=0", ld); else passed++;
    checks++; if (best_tap !== 5'd0) $display("FAIL abort_best_tap got=%0d exp=0", best_tap); else passed++;
    checks++; if (best_count !== 11'd512) $display("FAIL abort_best_count got=%0d exp=512", best_count); else passed++;
  endtask

  task automatic test_start_ignored();
    logic saw_ld;
    saw_ld = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_ld |= ld;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) $display("FAIL noready_busy got=%b exp=0", busy); else passed++;
    checks++; if (saw_ld !== 1'b0) $display("FAIL noready_ld got=%b exp=0", saw_ld); else passed++;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL noready_late_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    run_cal(1, 1'b0, 13);
    checks++; if (best_tap !== 5'd10) $display("FAIL mid_pre_best_tap got=%0d exp=10", best_tap); else passed++;
    checks++; if (cnt !== 5'd12) $display("FAIL mid_pre_cntvalue got=%0d exp=12", cnt); else passed++;
    aresetn = 1'b0;
    #1;
    checks++; if (ld !== 1'b0) $display("FAIL mid_ld got=%b exp=0", ld); else passed++;
    checks++; if (cnt !== 5'd0) $display("FAIL mid_cntvalue got=%0d exp=0", cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mid_done got=%b exp=0", done); else passed++;
    checks++; if (best_tap !== 5'd0) $display("FAIL mid_best_tap got=%0d exp=0", best_tap); else passed++;
    checks++; if (best_count !== 11'h7FF) $display("FAIL mid_best_count got=%0d exp=2047", best_count); else passed++;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL mid_after_busy got=%b exp=0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_saturation();
    test_window_min();
    test_single_best();
    test_valid_toggle();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
